// File: rtl/mult_leak_pkg.sv
// Shared definitions for the multiplier timing-leak monitor.
//   - state_e       : monitor FSM states
//   - DEF_*         : default operand width, counter width and trial timeout
//   - LAT_SENTINEL  : all-ones latency reported for a copy that never finished;
//                     users slice the low CNT_WIDTH bits (CNT_WIDTH <= 64)
package mult_leak_pkg;

  localparam int unsigned DEF_WIDTH     = 128;
  localparam int unsigned DEF_CNT_WIDTH = 16;
  localparam int unsigned DEF_TIMEOUT   = 1024;

  localparam logic [63:0] LAT_SENTINEL = '1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT_ONE,
    WAIT_TWO,
    REPORT
  } state_e;

endpackage

// File: rtl/mult_leak_capture.sv
// Per-copy capture slice: remembers whether this copy's done has been seen in
// the current trial, and the cycle count and product sampled at that moment.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears capture bit)
//   clear_i      : trial start, drops any previous capture
//   enable_i     : high while a trial is counting (RUN / WAIT states)
//   done_i       : done level from the monitored multiplier copy
//   cnt_i        : current trial cycle count
//   product_i    : product from the monitored copy
//   vld_o        : captured, including a capture happening this cycle
//   latency_o    : captured latency (this cycle's count on a fresh capture)
//   product_o    : captured product (this cycle's product on a fresh capture)
module mult_leak_capture
  import mult_leak_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic                   done_i,
  input  logic [CNT_WIDTH-1:0]   cnt_i,
  input  logic [2*WIDTH-1:0]     product_i,
  output logic                   vld_o,
  output logic [CNT_WIDTH-1:0]   latency_o,
  output logic [2*WIDTH-1:0]     product_o
);

  logic                 vld_q, vld_d;
  logic                 hit;
  logic [CNT_WIDTH-1:0] latency_q;
  logic [2*WIDTH-1:0]   product_q;

  // Only the first sampled done of a trial counts; a done held high afterwards
  // is masked by the capture bit.
  assign hit   = enable_i & done_i & ~vld_q;
  assign vld_d = clear_i ? 1'b0 : (vld_q | hit);

  // Effective values let the parent decide transitions and build the report
  // in the same cycle the last done arrives.
  assign vld_o     = vld_q | hit;
  assign latency_o = hit ? cnt_i : latency_q;
  assign product_o = hit ? product_i : product_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Data registers are only read while the capture bit is set.
  always_ff @(posedge clk) begin
    if (hit) begin
      latency_q <= cnt_i;
      product_q <= product_i;
    end
  end

endmodule

// File: rtl/mult_leak_monitor.sv
// Timing side-channel monitor for two identical multiplier copies driven by
// the same start strobe. Each trial counts cycles from the start edge and
// records when each copy's done first rises; differing latencies, differing
// products and timeouts raise sticky flags.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   start                          : trial start strobe (ignored unless idle)
//   productDoneOne/Two             : done levels of copy one / two
//   productOne/Two                 : products of copy one / two
//   busy                           : trial in progress (any non-idle state)
//   reportValid                    : one-cycle pulse, report outputs updated
//   latencyOne/Two                 : latencies of the last reported trial
//   timingLeak, productMismatch,
//   timeout                        : sticky anomaly flags
//   trialCount                     : completed trials, saturating
//   maxDelta                       : largest latency difference observed
module mult_leak_monitor
  import mult_leak_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 productDoneOne,
  input  logic                 productDoneTwo,
  input  logic [2*WIDTH-1:0]   productOne,
  input  logic [2*WIDTH-1:0]   productTwo,
  output logic                 busy,
  output logic                 reportValid,
  output logic [CNT_WIDTH-1:0] latencyOne,
  output logic [CNT_WIDTH-1:0] latencyTwo,
  output logic                 timingLeak,
  output logic                 productMismatch,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] trialCount,
  output logic [CNT_WIDTH-1:0] maxDelta
);

  localparam logic [CNT_WIDTH-1:0] LAT_NONE  = LAT_SENTINEL[CNT_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] abs_diff(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clear, active, rpt_entry;

  logic                 vld_one, vld_two, both;
  logic [CNT_WIDTH-1:0] lat_one, lat_two;
  logic [2*WIDTH-1:0]   prod_one, prod_two;

  logic                 rv_q;
  logic [CNT_WIDTH-1:0] lat_one_q, lat_two_q, trial_q, max_delta_q;
  logic                 leak_q, mism_q, tmo_q;

  logic [CNT_WIDTH-1:0] delta;
  logic                 leak_hit;

  assign active = (state_q == RUN) || (state_q == WAIT_ONE) || (state_q == WAIT_TWO);

  mult_leak_capture #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_cap_one (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .enable_i  (active),
    .done_i    (productDoneOne),
    .cnt_i     (cnt_q),
    .product_i (productOne),
    .vld_o     (vld_one),
    .latency_o (lat_one),
    .product_o (prod_one)
  );

  mult_leak_capture #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_cap_two (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .enable_i  (active),
    .done_i    (productDoneTwo),
    .cnt_i     (cnt_q),
    .product_i (productTwo),
    .vld_o     (vld_two),
    .latency_o (lat_two),
    .product_o (prod_two)
  );

  assign both = vld_one & vld_two;

  // The timeout fires when the count is about to reach TIMEOUT, so REPORT is
  // entered with the counter equal to TIMEOUT; the largest capturable
  // latency is therefore TIMEOUT-1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clear     = 1'b0;
    rpt_entry = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_WIDTH'(1);
          clear   = 1'b1;
        end
      end
      RUN, WAIT_ONE, WAIT_TWO: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (both) begin
          state_d = REPORT;
        end else if (cnt_d == TIMEOUT_C) begin
          state_d = REPORT;
        end else if (vld_two) begin
          state_d = WAIT_ONE;
        end else if (vld_one) begin
          state_d = WAIT_TWO;
        end else begin
          state_d = RUN;
        end
        rpt_entry = (state_d == REPORT);
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A single captured copy is always a leak; with neither captured both
  // latencies read the sentinel and only the timeout is flagged.
  assign delta    = abs_diff(lat_one, lat_two);
  assign leak_hit = (vld_one ^ vld_two) | (both & (lat_one != lat_two));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Report registers load on the edge into REPORT so they are valid
  // together with reportValid, and hold until the next report.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q        <= 1'b0;
      lat_one_q   <= '0;
      lat_two_q   <= '0;
      leak_q      <= 1'b0;
      mism_q      <= 1'b0;
      tmo_q       <= 1'b0;
      trial_q     <= '0;
      max_delta_q <= '0;
    end else begin
      rv_q <= rpt_entry;
      if (rpt_entry) begin
        lat_one_q <= vld_one ? lat_one : LAT_NONE;
        lat_two_q <= vld_two ? lat_two : LAT_NONE;
        trial_q   <= sat_inc(trial_q);
        if (leak_hit) begin
          leak_q <= 1'b1;
        end
        if (!both) begin
          tmo_q <= 1'b1;
        end
        if (both && (prod_one != prod_two)) begin
          mism_q <= 1'b1;
        end
        if (both && (delta > max_delta_q)) begin
          max_delta_q <= delta;
        end
      end
    end
  end

  assign busy            = (state_q != IDLE);
  assign reportValid     = rv_q;
  assign latencyOne      = lat_one_q;
  assign latencyTwo      = lat_two_q;
  assign timingLeak      = leak_q;
  assign productMismatch = mism_q;
  assign timeout         = tmo_q;
  assign trialCount      = trial_q;
  assign maxDelta        = max_delta_q;

endmodule

// File: tb/tb_mult_leak_monitor.sv
// Scoreboard bench for mult_leak_monitor. Two instances share the done and
// product stimulus: one with the default timeout and one with a 16-cycle
// timeout. Each trial is described by the first-done cycle of each copy and
// the products presented at those cycles; the expected report is derived
// from those numbers and queued, and a monitor compares it when reportValid
// pulses.
module tb_mult_leak_monitor;

  localparam int W     = 8;
  localparam int CW    = 16;
  localparam int TA    = 1024;
  localparam int TB    = 16;
  localparam int NEVER = 100000;
  localparam int ONES  = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start_a, start_b, d1, d2;
  logic [2*W-1:0]    p1, p2;

  logic              busy_a, rv_a, leak_a, mism_a, tmo_a;
  logic [CW-1:0]     lat1_a, lat2_a, tc_a, md_a;
  logic              busy_b, rv_b, leak_b, mism_b, tmo_b;
  logic [CW-1:0]     lat1_b, lat2_b, tc_b, md_b;

  mult_leak_monitor #(.WIDTH(W), .CNT_WIDTH(CW), .TIMEOUT(TA)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .productDoneOne(d1), .productDoneTwo(d2),
    .productOne(p1), .productTwo(p2),
    .busy(busy_a), .reportValid(rv_a),
    .latencyOne(lat1_a), .latencyTwo(lat2_a),
    .timingLeak(leak_a), .productMismatch(mism_a), .timeout(tmo_a),
    .trialCount(tc_a), .maxDelta(md_a)
  );

  mult_leak_monitor #(.WIDTH(W), .CNT_WIDTH(CW), .TIMEOUT(TB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .productDoneOne(d1), .productDoneTwo(d2),
    .productOne(p1), .productTwo(p2),
    .busy(busy_b), .reportValid(rv_b),
    .latencyOne(lat1_b), .latencyTwo(lat2_b),
    .timingLeak(leak_b), .productMismatch(mism_b), .timeout(tmo_b),
    .trialCount(tc_b), .maxDelta(md_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int lat1;
    int lat2;
    bit leak;
    bit mism;
    bit tmo;
    int tc;
    int md;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Model state per instance (0 = default timeout, 1 = short timeout).
  int m_lat1[2], m_lat2[2], m_tc[2], m_md[2];
  bit m_leak[2], m_mism[2], m_tmo[2];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Trial length in cycles from the start edge to the REPORT cycle.
  function automatic int rep_cycle(input int t, input int a, input int b);
    if (a < t && b < t) return max2(a, b) + 1;
    return t;
  endfunction

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      m_lat1[x] = 0; m_lat2[x] = 0; m_tc[x] = 0; m_md[x] = 0;
      m_leak[x] = 0; m_mism[x] = 0; m_tmo[x] = 0;
    end
  endtask

  task automatic model_trial(input int x, input int t, input int a, input int b,
                             input int pa, input int pb, input int t0);
    bit   c1, c2;
    exp_t e;
    c1 = (a < t);
    c2 = (b < t);
    m_lat1[x] = c1 ? a : ONES;
    m_lat2[x] = c2 ? b : ONES;
    if (!(c1 && c2)) m_tmo[x] = 1;
    if ((c1 != c2) || (c1 && c2 && a != b)) m_leak[x] = 1;
    if (c1 && c2 && pa != pb) m_mism[x] = 1;
    if (c1 && c2) m_md[x] = max2(m_md[x], (a > b) ? a - b : b - a);
    if (m_tc[x] < ONES) m_tc[x]++;
    e.cyc  = t0 + rep_cycle(t, a, b) - 1;
    e.lat1 = m_lat1[x]; e.lat2 = m_lat2[x];
    e.leak = m_leak[x]; e.mism = m_mism[x]; e.tmo = m_tmo[x];
    e.tc   = m_tc[x];   e.md   = m_md[x];
    if (x == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic compare_report(input int x, input exp_t e,
                                input logic [CW-1:0] l1, input logic [CW-1:0] l2,
                                input logic lk, input logic mm, input logic to,
                                input logic [CW-1:0] tc, input logic [CW-1:0] md);
    string s;
    s = (x == 0) ? "a" : "b";
    chk({"rep_cycle_", s}, cyc, e.cyc);
    chk({"latencyOne_", s}, l1, e.lat1);
    chk({"latencyTwo_", s}, l2, e.lat2);
    chk({"timingLeak_", s}, lk, e.leak);
    chk({"productMismatch_", s}, mm, e.mism);
    chk({"timeout_", s}, to, e.tmo);
    chk({"trialCount_", s}, tc, e.tc);
    chk({"maxDelta_", s}, md, e.md);
  endtask

  // Monitor: pops an expectation whenever an instance reports.
  always @(negedge clk) begin
    if (rv_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_report_a: got report with empty queue at t=%0t", $time);
      end else begin
        compare_report(0, q_a.pop_front(), lat1_a, lat2_a, leak_a, mism_a, tmo_a, tc_a, md_a);
      end
    end
    if (rv_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_report_b: got report with empty queue at t=%0t", $time);
      end else begin
        compare_report(1, q_b.pop_front(), lat1_b, lat2_b, leak_b, mism_b, tmo_b, tc_b, md_b);
      end
    end
  end

  // Outputs between reports must hold the last reported values.
  task automatic hold_check(input string tag);
    chk({tag, "_busy_a"}, busy_a, 0);
    chk({tag, "_rv_a"}, rv_a, 0);
    chk({tag, "_lat1_a"}, lat1_a, m_lat1[0]);
    chk({tag, "_lat2_a"}, lat2_a, m_lat2[0]);
    chk({tag, "_flags_a"}, {leak_a, mism_a, tmo_a}, {m_leak[0], m_mism[0], m_tmo[0]});
    chk({tag, "_tc_a"}, tc_a, m_tc[0]);
    chk({tag, "_md_a"}, md_a, m_md[0]);
    chk({tag, "_busy_b"}, busy_b, 0);
    chk({tag, "_rv_b"}, rv_b, 0);
    chk({tag, "_lat1_b"}, lat1_b, m_lat1[1]);
    chk({tag, "_lat2_b"}, lat2_b, m_lat2[1]);
    chk({tag, "_flags_b"}, {leak_b, mism_b, tmo_b}, {m_leak[1], m_mism[1], m_tmo[1]});
    chk({tag, "_tc_b"}, tc_b, m_tc[1]);
    chk({tag, "_md_b"}, md_b, m_md[1]);
  endtask

  // One trial: a = first done cycle of copy one, b = of copy two (NEVER for
  // none), pa/pb products presented in those cycles, s = cycle of a stray
  // start pulse (0 for none), abort = cycle in which rst is asserted (0 none).
  task automatic run_trial(input int a, input int b, input int pa, input int pb,
                           input int s, input int abort);
    int ra, rb, lim, sa, sb, t0;
    ra  = rep_cycle(TA, a, b);
    rb  = rep_cycle(TB, a, b);
    lim = (abort != 0) ? abort : max2(ra, rb);
    sa  = (s > ra && s != abort) ? ra : s;
    sb  = (s > rb && s != abort) ? rb : s;

    @(negedge clk);
    hold_check("hold");
    start_a = 1; start_b = 1; d1 = 0; d2 = 0;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_a = 0; start_b = 0;
    if (abort == 0 || ra <= abort) model_trial(0, TA, a, b, pa, pb, t0);
    if (abort == 0 || rb <= abort) model_trial(1, TB, a, b, pa, pb, t0);

    for (int c = 1; c <= lim; c++) begin
      d1      = (c >= a);
      d2      = (c >= b);
      p1      = (c == a) ? 16'(pa) : 16'($urandom);
      p2      = (c == b) ? 16'(pb) : 16'($urandom);
      start_a = (c == sa);
      start_b = (c == sb);
      rst     = (c == abort);
      @(posedge clk);
      #1;
    end
    start_a = 0; start_b = 0; rst = 0; d1 = 0; d2 = 0;

    if (abort != 0) begin
      model_reset();
      @(negedge clk);
      hold_check("after_reset");
    end else begin
      @(negedge clk);
      chk("idle_busy_a", busy_a, 0);
      chk("idle_busy_b", busy_b, 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a, b, pa, pb, s, ab;
    rst = 1; start_a = 0; start_b = 0; d1 = 0; d2 = 0; p1 = '0; p2 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    start_a = 1; start_b = 1;           // start during reset is overridden
    @(posedge clk);
    #1;
    start_a = 0; start_b = 0; rst = 0;
    @(negedge clk);
    hold_check("reset_state");

    run_trial(130, 130, 16'h1234, 16'h1234, 0, 0);   // equal latencies
    run_trial(128, 131, 16'h0042, 16'h0042, 0, 0);   // skewed latencies
    run_trial(130, 130, 16'h0001, 16'h0001, 0, 0);   // sticky after equal trial
    run_trial(10, 10, 16'h0006, 16'h0007, 0, 0);     // product mismatch
    run_trial(5, NEVER, 16'h0009, 16'h0000, 0, 0);   // timeout on one copy
    run_trial(100, 100, 16'h0011, 16'h0011, 50, 50); // reset mid-trial, start with rst
    run_trial(NEVER, NEVER, 16'h0, 16'h0, 0, 0);     // neither finishes
    run_trial(40, 40, 16'h00AA, 16'h00AA, 20, 0);    // start while busy
    run_trial(15, 15, 16'h0003, 16'h0003, 0, 0);     // last capturable cycle, short timeout
    run_trial(16, 3, 16'h0004, 16'h0004, 16, 0);     // done at timeout cycle, start in REPORT

    for (int i = 0; i < 30; i++) begin
      a  = $urandom_range(1, 200);
      b  = ($urandom_range(0, 2) == 0) ? a : $urandom_range(1, 200);
      if ($urandom_range(0, 19) == 0) b = NEVER;
      pa = $urandom_range(0, 65535);
      pb = ($urandom_range(0, 1) == 0) ? pa : $urandom_range(0, 65535);
      s  = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 60) : 0;
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 60) : 0;
      run_trial(a, b, pa, pb, s, ab);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
